// File: rtl/vliw_packet_loader.sv
// Assembles a stream of 32-bit instruction words into ten-slot VLIW packets
// and writes each packet to consecutive instruction-memory addresses.
module vliw_packet_loader #(
  parameter int SLOTS  = 10,
  parameter int WORD   = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD-1:0]         in_word,
  input  logic                    in_last,
  input  logic                    in_eop,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [SLOTS*WORD-1:0]   mem_packet,
  output logic [ADDR_W:0]         pkt_count,
  output logic                    done,
  output logic                    overflow
);

  localparam int CNT_W = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        slot_cnt;
  logic [SLOTS*WORD-1:0]   pkt_buf;
  logic [SLOTS*WORD-1:0]   buf_nxt;
  logic                    eop_seen;
  logic                    accept;
  logic                    closing;
  logic                    launch;
  logic                    last_addr;

  // Slot 0 sits in the most significant word; a packet-closing word
  // zero-fills every slot above it.
  function automatic logic [SLOTS*WORD-1:0] place_word(
    input logic [SLOTS*WORD-1:0] cur,
    input logic [CNT_W-1:0]      slot,
    input logic [WORD-1:0]       word,
    input logic                  pad
  );
    logic [SLOTS*WORD-1:0] r;
    r = cur;
    for (int s = 0; s < SLOTS; s++) begin
      if (s == int'(slot)) begin
        r[(SLOTS-1-s)*WORD +: WORD] = word;
      end else if (pad && (s > int'(slot))) begin
        r[(SLOTS-1-s)*WORD +: WORD] = '0;
      end
    end
    return r;
  endfunction

  assign in_ready  = (state == FILL);
  assign mem_we    = (state == COMMIT);
  assign accept    = in_valid && in_ready;
  assign closing   = in_last || in_eop || (slot_cnt == CNT_W'(SLOTS - 1));
  assign launch    = start && ((state == IDLE) || (state == DONE));
  assign last_addr = (mem_addr == ADDR_W'(DEPTH - 1));
  assign buf_nxt   = place_word(pkt_buf, slot_cnt, in_word, in_last || in_eop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (accept && closing) state_nxt = COMMIT;
      COMMIT:  state_nxt = (eop_seen || last_addr) ? DONE : FILL;
      DONE:    if (start) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: sequencing, addressing, status and the committed packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      mem_addr   <= '0;
      pkt_count  <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      eop_seen   <= 1'b0;
      mem_packet <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            slot_cnt  <= '0;
            mem_addr  <= '0;
            pkt_count <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            eop_seen  <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            slot_cnt <= slot_cnt + CNT_W'(1);
            if (in_eop) eop_seen <= 1'b1;
            if (closing) mem_packet <= buf_nxt;
          end
        end
        COMMIT: begin
          pkt_count <= pkt_count + (ADDR_W+1)'(1);
          slot_cnt  <= '0;
          // The top address is never exceeded: the address holds instead of wrapping.
          if (!last_addr) mem_addr <= mem_addr + ADDR_W'(1);
          if (eop_seen || last_addr) done <= 1'b1;
          if (last_addr && !eop_seen) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Packet assembly buffer; cleared on every new load and after each commit.
  always_ff @(posedge clk) begin
    if (launch || (state == COMMIT)) begin
      pkt_buf <= '0;
    end else if (accept) begin
      pkt_buf <= buf_nxt;
    end
  end

endmodule

// File: doc/vliw_packet_loader.md
# vliw_packet_loader

Upstream loader for the VLIW processor's instruction memory. Accepts a serial stream of 32-bit instruction words over a valid/ready handshake and assembles them into 320-bit, ten-slot packets. Writes each completed packet into the processor's packet-wide instruction memory at consecutive addresses from 0. Short packets are padded with NOP (all-zero) slots; the block reports completion or overflow.

## Interface
- SLOTS, 10, instruction slots per packet (slot order: add0, add1, mul, fadd0, fadd1, fmul, logic, ldr, str, mov)
- WORD, 32, bits per slot
- DEPTH, 1024, instruction memory depth in packets
- ADDR_W, 10, address width, equal to clog2(DEPTH)

- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a load; ignored unless the state is IDLE or DONE
- in_valid  in  1  instruction word valid
- in_ready  out  1  block can accept a word
- in_word  in  WORD  instruction word
- in_last  in  1  marks the final word of the current packet; remaining slots are zero-padded
- in_eop  in  1  marks the final word of the program; implies in_last
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  ADDR_W  packet address for the write
- mem_packet  out  SLOTS*WORD  assembled packet; slot 0 occupies bits [319:288], slot 9 occupies bits [31:0]
- pkt_count  out  ADDR_W+1  number of packets written since start
- done  out  1  level signal; load finished
- overflow  out  1  level signal; memory filled before in_eop was seen

## Operation
- States and transitions:
  - IDLE: go to FILL on start.
  - FILL: go to COMMIT after accepting the slot-9 word, or any word with in_last or in_eop set.
  - COMMIT: go to DONE if the packet was in_eop-terminated or mem_addr == DEPTH-1; otherwise go to FILL.
  - DONE: go to FILL on start.
- Entering FILL from start clears slot_cnt, mem_addr, pkt_count, done, overflow, the eop latch, and the packet buffer.
- FILL: in_ready=1. On in_valid&&in_ready, write in_word into slot slot_cnt and increment slot_cnt.
  - When the accepted word has in_last or in_eop, force all slots above slot_cnt to zero.
  - Latch in_eop.
- COMMIT: in_ready=0, mem_we=1, and mem_packet/mem_addr hold the packet and its address.
  - On the next edge: mem_addr += 1, pkt_count += 1, slot_cnt=0, buffer cleared.
- If COMMIT writes address DEPTH-1 without the eop latch set, set overflow=1 and go to DONE. No write ever targets an address ≥ DEPTH, and mem_addr does not wrap.
- DONE: done=1, in_ready=0. Words offered in DONE are not consumed.
- start while in FILL or COMMIT is ignored.
- in_eop on a word with slot_cnt==9 behaves identically to in_last plus the eop latch.
- in_valid deasserted mid-packet stalls FILL indefinitely; slot_cnt and the buffer are held.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_packet 0, pkt_count 0, done 0, overflow 0; state IDLE.
- rst has priority over every other input. Asserting rst mid-packet discards the partial packet with no write. Asserting rst during COMMIT suppresses the strobe from the next cycle on.
- start sampled at edge t: in_ready=1 from cycle t+1.
- Packet-closing word accepted at edge t: mem_we=1 during cycle t+1, in_ready=1 again at t+2 unless going to DONE.
- Full packets sustain 10 words per 11 cycles.
- done rises in the cycle after the final COMMIT, together with the final pkt_count value.
- mem_packet and mem_addr are stable for the whole mem_we cycle. mem_packet holds its last value otherwise.

## Test plan
- Ten words 0x1000_0000..0x1000_0009 with the last carrying in_eop → one write at addr 0, packet[319:288]=0x1000_0000, packet[31:0]=0x1000_0009, pkt_count=1, done=1.
- Three words A,B,C with in_last on C, then ten words with in_eop on the tenth → addr 0 packet = {A,B,C,7×0}, addr 1 full, pkt_count=2.
- DEPTH=4 and 50 continuous words without in_eop → writes at addr 0..3, overflow=1, done=1, in_ready=0, remaining words unconsumed.
- in_valid toggled randomly (50%) over 20 words → packets are identical to the back-to-back case; mem_we never coincides with in_ready.
- rst asserted after 5 words of packet 1, then a fresh start → no write for the partial packet; the new load starts at addr 0 with pkt_count=0.
- start pulsed during FILL and again in DONE → ignored in FILL; in DONE it restarts with done=0, overflow=0, mem_addr=0.
